instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 56 +++++
 rtl/instr_fetch.sv | 123 ++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_fifo.sv
// Registered FIFO buffering fetched instructions; flush may coincide with a push
// that then becomes the only entry.
module fetch_fifo #(
  parameter int unsigned      DEPTH     = 2,
  parameter int unsigned      WIDTH     = 65,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_pop;
  logic             do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= RESET_VAL;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= push ? ptr_inc(PTR_W'(0)) : PTR_W'(0);
      count  <= push ? CNT_W'(1) : CNT_W'(0);
      if (push) mem[0] <= din;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues in-order memory requests, buffers responses for ID,
// and handles redirects, misaligned targets and bus errors (HALT until redirect).
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_err_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        instr_valid_o,
  output logic [31:0] instruction_o,
  output logic [31:0] pc_o,
  output logic        instr_fault_o
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [1:0]       state, state_n;
  logic [31:0]      fetch_pc, fetch_pc_n;
  logic [31:0]      resp_pc, resp_pc_n;
  logic [CNT_W-1:0] outstanding, outstanding_n;
  logic [CNT_W-1:0] discard, discard_n;
  logic [CNT_W-1:0] buf_count;
  logic             grant;
  logic             push, pop, flush;
  fetch_entry_t     push_entry;
  fetch_entry_t     head;

  // Credit check counts buffered entries before this cycle's pop.
  assign imem_req_o = (state == ST_RUN) && !redirect_i &&
                      ((SUM_W'(outstanding) + SUM_W'(buf_count)) < SUM_W'(BUF_DEPTH));
  assign imem_addr_o = fetch_pc;
  assign grant       = imem_req_o && imem_gnt_i;

  assign instr_valid_o = (buf_count != '0);
  assign pop           = instr_valid_o && id_ready_i;
  assign instruction_o = head.instr;
  assign pc_o          = head.pc;
  assign instr_fault_o = head.fault;

  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    resp_pc_n     = resp_pc;
    outstanding_n = outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid_i);
    discard_n     = discard;
    push          = 1'b0;
    flush         = 1'b0;
    push_entry    = '{pc: resp_pc, instr: imem_rdata_i, fault: 1'b0};

    if (grant) fetch_pc_n = fetch_pc + 32'd4;
    if (state == ST_BOOT) state_n = ST_RUN;

    if ((state != ST_BOOT) && redirect_i) begin
      // Everything still in flight belongs to the old stream.
      flush      = 1'b1;
      fetch_pc_n = redirect_pc_i;
      resp_pc_n  = redirect_pc_i;
      discard_n  = outstanding - CNT_W'(imem_rvalid_i);
      state_n    = ST_RUN;
      if (redirect_pc_i[1:0] != 2'b00) begin
        push       = 1'b1;
        push_entry = '{pc: redirect_pc_i, instr: INSTR_NOP, fault: 1'b1};
        state_n    = ST_HALT;
      end
    end else if (imem_rvalid_i) begin
      if (discard != '0) begin
        discard_n = discard - CNT_W'(1);
      end else begin
        push      = 1'b1;
        resp_pc_n = resp_pc + 32'd4;
        if (imem_err_i) begin
          push_entry = '{pc: resp_pc, instr: INSTR_NOP, fault: 1'b1};
          state_n    = ST_HALT;
          discard_n  = outstanding_n;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      state       <= state_n;
      fetch_pc    <= fetch_pc_n;
      resp_pc     <= resp_pc_n;
      outstanding <= outstanding_n;
      discard     <= discard_n;
    end
  end

  fetch_fifo #(
    .DEPTH     (BUF_DEPTH),
    .WIDTH     (ENTRY_W),
    .RESET_VAL (ENTRY_W'({RESET_PC, INSTR_NOP, 1'b0}))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (push_entry),
    .dout  (head),
    .count (buf_count)
  );

endmodule
